countdown_timer_ctrl: RTL and testbench
=======================================

Name: countdown_timer_ctrl

Overview:
- Sequencer for a cascaded BCD down-counter chain used as a countdown timer (e.g. MM:SS digits).
- Issues the load, count-enable and sync-reset strobes to the chain and derives the count tick from the system clock.
- Monitors the chain's all-zero flag and steps through load, run, pause, alarm and done phases in response to start/pause/clear pulses.

Parameters:
- TICK_DIV, 100000000: clk cycles per count tick (1 Hz at 100 MHz). Must be ≥2.
- DIV_W, 27: divider width. Must be ≥ clog2(TICK_DIV).
- ALARM_TICKS, 5: ticks the alarm stays asserted before auto-entering DONE. Range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse: load preset and run; also acknowledges alarm.
- pause  in  1  one-cycle pulse: toggles RUN/PAUSE; also acknowledges alarm.
- clear  in  1  one-cycle pulse: abort to IDLE and reset the chain.
- chain_zero  in  1  high when every digit of the external chain is 0 (combinational from the chain).
- cnt_load  out  1  one-cycle load strobe to every digit.
- cnt_ce  out  1  one-cycle count enable to the least-significant digit.
- cnt_reset  out  1  one-cycle synchronous reset strobe to the chain.
- running  out  1  high in RUN.
- paused  out  1  high in PAUSE.
- alarm  out  1  high in ALARM.
- done  out  1  high in DONE.
- state  out  3  encoded state, for debug.

Behaviour:
- States and encodings: IDLE=0, CLEAR=1, LOAD=2, CHECK=3, RUN=4, PAUSE=5, ALARM=6, DONE=7.
- Reset, asynchronous: state=IDLE, divider=0, alarm counter=0, all outputs 0.
- Input priority within a cycle: clear > start > pause. Lower-priority pulses in the same cycle are dropped.
- clear in any state except CLEAR: next state is CLEAR.
- CLEAR: cnt_reset=1 for exactly one cycle, then IDLE. Divider and alarm counter are zeroed.
- IDLE:
  - start → LOAD.
  - pause is ignored.
- LOAD: cnt_load=1 for exactly one cycle, then CHECK.
- CHECK: one settling cycle so chain_zero reflects the loaded value.
  - chain_zero=1 → ALARM (zero preset).
  - Otherwise → RUN with divider=0.
- RUN:
  - Divider increments every cycle. At TICK_DIV-1 it wraps to 0 and raises the internal tick.
  - cnt_ce = (state==RUN) && tick && !chain_zero. This is combinational, one cycle wide.
  - CE is never issued while the chain is zero; this prevents the chain's wrap to 9.
  - chain_zero=1 → ALARM. Divider cleared.
  - pause → PAUSE. Divider holds its value.
  - start is ignored.
- PAUSE:
  - Divider frozen. cnt_ce=0.
  - pause → RUN, divider resumes from its held value.
  - start is ignored.
- ALARM:
  - alarm=1.
  - Divider runs as in RUN. Each tick increments the alarm counter.
  - When the alarm counter reaches ALARM_TICKS → DONE.
  - start or pause (acknowledge) → DONE on the next edge.
  - The alarm counter is cleared on exit.
- DONE:
  - done=1. Counter chain holds 0.
  - start → LOAD (restart with the same preset).
  - pause is ignored.
- Status outputs running, paused, alarm, done and cnt_load, cnt_reset are Moore decodes of the state register. No extra latency.
- Latency:
  - start sampled at edge N → cnt_load high in cycle N+1.
  - RUN entered at N+3.
  - First cnt_ce occurs in the TICK_DIV-th cycle of RUN.
- Only one of cnt_load, cnt_ce, cnt_reset is ever high in a given cycle.

Test Plan:
- Bench setup: TICK_DIV=4, ALARM_TICKS=2, with a behavioural single-digit chain model. The preset for each scenario is given in that scenario.
- Reset mid-RUN (divider=2): outputs go to 0 and state=0 immediately, asynchronously. After release, the block stays IDLE with no strobes.
- Preset 3, start pulse:
  - One cnt_load, then CHECK, then RUN.
  - cnt_ce in RUN cycles 4, 8, 12. Chain goes 2, 1, 0.
  - ALARM is entered the cycle after chain_zero rises, with no further cnt_ce.
  - alarm high for 8 cycles (2 ticks), then done=1.
- Preset 0, start: LOAD → CHECK → ALARM directly. cnt_ce never asserted.
- Preset 5, pause after 6 RUN cycles:
  - paused=1, divider frozen at 2, no cnt_ce for 20 cycles.
  - A second pause resumes; the next cnt_ce comes after 2 RUN cycles.
- In ALARM, pulse start: DONE on the next edge.
  - A further start gives a cnt_load pulse and the run restarts.
  - clear together with start in DONE: CLEAR wins (cnt_reset for 1 cycle, then IDLE, no cnt_load).
- clear during PAUSE: one-cycle cnt_reset, then IDLE. A start pulse in the same cycle as clear is dropped.

Source files
------------

// File: rtl/countdown_timer_ctrl.sv
// Sequencer for a cascaded BCD down-counter chain used as a countdown timer.
// It drives the load, count-enable and reset strobes to the chain, and divides
// clk down to the count tick. It also watches the chain's all-zero flag to step
// through the load, run, pause, alarm and done phases.
//
// Pulse semantics: start, pause and clear are one-cycle pulses sampled on the
// rising edge. Priority within a cycle is clear > start > pause, and a
// lower-priority pulse in the same cycle is dropped. cnt_load, cnt_ce and
// cnt_reset are one-cycle strobes, and no two of them are ever high together.
module countdown_timer_ctrl #(
    parameter int TICK_DIV    = 100000000,
    parameter int DIV_W       = 27,
    parameter int ALARM_TICKS = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       pause,
    input  logic       clear,
    input  logic       chain_zero,
    output logic       cnt_load,
    output logic       cnt_ce,
    output logic       cnt_reset,
    output logic       running,
    output logic       paused,
    output logic       alarm,
    output logic       done,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_LOAD  = 3'd2,
        ST_CHECK = 3'd3,
        ST_RUN   = 3'd4,
        ST_PAUSE = 3'd5,
        ST_ALARM = 3'd6,
        ST_DONE  = 3'd7
    } state_t;

    localparam logic [DIV_W-1:0] DIV_MAX    = DIV_W'(TICK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE    = DIV_W'(1);
    localparam logic [7:0]       ALARM_LAST = 8'(ALARM_TICKS - 1);

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [7:0]       alarm_cnt_q, alarm_cnt_d;
    logic             pausing;
    logic             advance;
    logic             tick;

    // The divider advances only in cycles that stay in RUN/ALARM. A pause
    // cycle holds the divider, so a tick is never issued twice for one count.
    always_comb begin
        pausing = pause && !start && !clear;
        advance = ((state_q == ST_RUN) && !pausing && !clear) ||
                  ((state_q == ST_ALARM) && !clear);
        tick    = advance && (div_q == DIV_MAX);
    end

    // Next-state logic together with the divider and alarm-counter updates.
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        alarm_cnt_d = alarm_cnt_q;

        if (clear && (state_q != ST_CLEAR)) begin
            state_d = ST_CLEAR;
        end else begin
            case (state_q)
                ST_IDLE:  if (start) state_d = ST_LOAD;
                ST_CLEAR: state_d = ST_IDLE;
                ST_LOAD:  state_d = ST_CHECK;
                ST_CHECK: state_d = chain_zero ? ST_ALARM : ST_RUN;
                ST_RUN: begin
                    if (chain_zero)   state_d = ST_ALARM;
                    else if (pausing) state_d = ST_PAUSE;
                end
                ST_PAUSE: if (pausing) state_d = ST_RUN;
                ST_ALARM: begin
                    if (start || pause)                          state_d = ST_DONE;
                    else if (tick && (alarm_cnt_q == ALARM_LAST)) state_d = ST_DONE;
                end
                ST_DONE:  if (start) state_d = ST_LOAD;
                default:  state_d = ST_IDLE;
            endcase
        end

        // The divider runs in RUN/ALARM and holds in RUN-pause and PAUSE.
        // It is zero everywhere else, so each run starts a fresh tick period.
        if (advance) begin
            div_d = tick ? '0 : div_q + DIV_ONE;
        end else if ((state_q != ST_RUN) && (state_q != ST_PAUSE)) begin
            div_d = '0;
        end
        if ((state_q == ST_RUN) && chain_zero) begin
            div_d = '0;
        end

        // The alarm counter counts ticks while ALARM persists and is zero otherwise.
        if ((state_q == ST_ALARM) && (state_d == ST_ALARM)) begin
            if (tick) alarm_cnt_d = alarm_cnt_q + 8'd1;
        end else begin
            alarm_cnt_d = 8'd0;
        end
    end

    // State, divider and alarm-counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            div_q       <= '0;
            alarm_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            alarm_cnt_q <= alarm_cnt_d;
        end
    end

    // Moore decodes of the state, plus the tick-qualified count enable.
    always_comb begin
        cnt_load  = (state_q == ST_LOAD);
        cnt_reset = (state_q == ST_CLEAR);
        cnt_ce    = (state_q == ST_RUN) && tick && !chain_zero;
        running   = (state_q == ST_RUN);
        paused    = (state_q == ST_PAUSE);
        alarm     = (state_q == ST_ALARM);
        done      = (state_q == ST_DONE);
        state     = state_q;
    end

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Bench for countdown_timer_ctrl. A single-digit BCD chain model closes the loop.
// The reference model predicts the per-cycle outputs from elapsed-cycle
// arithmetic. A monitor compares those predictions against the DUT.
module tb_countdown_timer_ctrl;

  localparam int TICK_DIV    = 4;
  localparam int ALARM_TICKS = 2;

  localparam int IDLE  = 0;
  localparam int CLEAR = 1;
  localparam int LOAD  = 2;
  localparam int CHECK = 3;
  localparam int RUN   = 4;
  localparam int PAUSE = 5;
  localparam int ALARM = 6;
  localparam int DONE  = 7;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       clear = 1'b0;
  logic       chain_zero;
  logic       cnt_load, cnt_ce, cnt_reset;
  logic       running, paused, alarm, done;
  logic [2:0] state;

  logic [3:0] preset = 4'd0;
  logic [3:0] cur_preset = 4'd0;
  logic [3:0] chain_digit = 4'd0;

  logic [9:0] exp_q[$];
  int         n_vec = 0;
  int         n_fail = 0;
  int         cyc = 0;

  // Reference model state.
  int m_st = IDLE;
  int m_digit = 0;
  int m_elapsed = 0;
  int m_acyc = 0;

  countdown_timer_ctrl #(
    .TICK_DIV(TICK_DIV),
    .DIV_W(3),
    .ALARM_TICKS(ALARM_TICKS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .pause(pause),
    .clear(clear),
    .chain_zero(chain_zero),
    .cnt_load(cnt_load),
    .cnt_ce(cnt_ce),
    .cnt_reset(cnt_reset),
    .running(running),
    .paused(paused),
    .alarm(alarm),
    .done(done),
    .state(state)
  );

  // clock / timeout
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  // External single-digit BCD chain.
  always @(posedge clk) begin
    if (cnt_reset) chain_digit <= 4'd0;
    else if (cnt_load) chain_digit <= preset;
    else if (cnt_ce) chain_digit <= (chain_digit == 4'd0) ? 4'd9 : chain_digit - 4'd1;
  end
  assign chain_zero = (chain_digit == 4'd0);

  // One stimulus cycle: drive pulses, predict this cycle's outputs, advance model.
  task automatic step(input logic s, input logic p, input logic c);
    logic       ce;
    logic       pz;
    logic [9:0] e;
    @(posedge clk);
    #1;
    start = s;
    pause = p;
    clear = c;
    preset = cur_preset;
    pz = p && !s;
    ce = (m_st == RUN) && !c && !pz && (m_digit != 0) &&
         (((m_elapsed + 1) % TICK_DIV) == 0);
    e = {3'(m_st), m_st == LOAD, ce, m_st == CLEAR, m_st == RUN,
         m_st == PAUSE, m_st == ALARM, m_st == DONE};
    exp_q.push_back(e);
    if (c && m_st != CLEAR) begin
      m_st = CLEAR;
    end else begin
      case (m_st)
        IDLE:  if (s) m_st = LOAD;
        CLEAR: begin m_digit = 0; m_st = IDLE; end
        LOAD:  begin m_digit = int'(cur_preset); m_st = CHECK; end
        CHECK: begin
          if (m_digit == 0) begin m_st = ALARM; m_acyc = 0; end
          else begin m_st = RUN; m_elapsed = 0; end
        end
        RUN: begin
          if (m_digit == 0) begin m_st = ALARM; m_acyc = 0; end
          else if (pz) m_st = PAUSE;
          else begin
            if (ce) m_digit = m_digit - 1;
            m_elapsed = m_elapsed + 1;
          end
        end
        PAUSE: if (pz) m_st = RUN;
        ALARM: begin
          if (s || p) m_st = DONE;
          else begin
            m_acyc = m_acyc + 1;
            if (m_acyc == ALARM_TICKS * TICK_DIV) m_st = DONE;
          end
        end
        DONE: if (s) m_st = LOAD;
        default: m_st = IDLE;
      endcase
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  // Asynchronous reset mid-cycle: outputs must clear without waiting for an edge.
  task automatic do_reset();
    logic [9:0] got;
    @(posedge clk);
    #1;
    start = 1'b0; pause = 1'b0; clear = 1'b0;
    reset = 1'b1;
    #1;
    got = {state, cnt_load, cnt_ce, cnt_reset, running, paused, alarm, done};
    n_vec++;
    if (got !== 10'd0) begin
      n_fail++;
      $display("FAIL async_reset: got %b required %b", got, 10'd0);
    end
    repeat (2) @(posedge clk);
    #1;
    got = {state, cnt_load, cnt_ce, cnt_reset, running, paused, alarm, done};
    n_vec++;
    if (got !== 10'd0) begin
      n_fail++;
      $display("FAIL held_reset: got %b required %b", got, 10'd0);
    end
    reset = 1'b0;
    m_st = IDLE; m_elapsed = 0; m_acyc = 0;
  endtask

  // Scoreboard monitor: one expected vector per driven cycle.
  always @(negedge clk) begin
    logic [9:0] got;
    logic [9:0] exp;
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      got = {state, cnt_load, cnt_ce, cnt_reset, running, paused, alarm, done};
      n_vec++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL cycle_outputs @%0d: got st=%0d ld/ce/rst=%b%b%b r/p/a/d=%b%b%b%b required st=%0d ld/ce/rst=%b%b%b r/p/a/d=%b%b%b%b",
                 cyc, got[9:7], got[6], got[5], got[4], got[3], got[2], got[1], got[0],
                 exp[9:7], exp[6], exp[5], exp[4], exp[3], exp[2], exp[1], exp[0]);
      end
    end
  end

  initial begin
    logic s, p, c;
    do_reset();
    idle(3);
    step(1'b0, 1'b1, 1'b0);          // pause in IDLE is ignored
    idle(2);

    // Reset while in RUN with the divider at 2.
    cur_preset = 4'd5;
    step(1'b1, 1'b0, 1'b0);
    idle(4);                         // LOAD, CHECK, RUN1, RUN2
    do_reset();
    idle(6);

    // Preset 3: three counts, alarm for two ticks, then done.
    cur_preset = 4'd3;
    step(1'b1, 1'b0, 1'b0);
    idle(30);

    // Preset 0: straight to ALARM.
    cur_preset = 4'd0;
    step(1'b1, 1'b0, 1'b0);
    idle(14);

    // Preset 5 with pause after six RUN cycles.
    cur_preset = 4'd5;
    step(1'b1, 1'b0, 1'b0);
    idle(8);                         // LOAD, CHECK, RUN1..RUN6
    step(1'b0, 1'b1, 1'b0);
    idle(20);
    step(1'b0, 1'b1, 1'b0);
    idle(40);

    // Acknowledge alarm with start, restart, then clear+start in DONE.
    cur_preset = 4'd1;
    step(1'b1, 1'b0, 1'b0);
    idle(8);                         // LOAD .. ALARM1
    step(1'b1, 1'b0, 1'b0);          // ack in ALARM2
    idle(2);
    step(1'b1, 1'b0, 1'b0);          // restart from DONE
    idle(25);
    step(1'b1, 1'b0, 1'b1);          // clear wins
    idle(4);

    // clear + start during PAUSE.
    cur_preset = 4'd5;
    step(1'b1, 1'b0, 1'b0);
    idle(5);
    step(1'b0, 1'b1, 1'b0);
    idle(3);
    step(1'b1, 1'b0, 1'b1);
    idle(4);

    // Randomised pulse traffic.
    for (int i = 0; i < 600; i++) begin
      s = ($urandom_range(0, 11) == 0);
      p = ($urandom_range(0, 13) == 0);
      c = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 7) == 0) cur_preset = 4'($urandom_range(0, 9));
      step(s, p, c);
    end
    idle(2);

    @(posedge clk);
    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
